// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, addresses the combinational ROM and
// registers {instruction, PC, PC+4, valid} for decode, with stall/flush/redirect.
module instruction_fetch_unit #(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    localparam int         ADDR_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Branch_Taken_i,
    input  logic [31:0]           Branch_Target_i,
    input  logic [DATA_WIDTH-1:0] Rom_Instruction_i,
    output logic [ADDR_W-1:0]     Rom_Address_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [31:0]           PC_o,
    output logic [31:0]           PC_Plus_4_o,
    output logic                  Valid_o,
    output logic                  Fault_o
);

    localparam logic [31:0]           ROM_BYTES = 32'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pc_plus_4;

    // Wrapped offset from RESET_PC: addresses below the ROM or wrapped past
    // 2^32 land far above ROM_BYTES, so one unsigned compare covers both ends.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RESET_PC;
        return (off < ROM_BYTES) && (addr[1:0] == 2'b00);
    endfunction

    assign pc_plus_4     = pc_q + 32'd4;
    // pc_q is always word aligned, so the word index subtracts without borrow.
    assign Rom_Address_o = pc_q[ADDR_W+1:2] - RESET_PC[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            pc_q          <= RESET_PC;
            Instruction_o <= NOP;
            PC_o          <= RESET_PC;
            PC_Plus_4_o   <= RESET_PC + 32'd4;
            Valid_o       <= 1'b0;
            Fault_o       <= 1'b0;
        end else if (state == HALT) begin
            Instruction_o <= NOP;
            Valid_o       <= 1'b0;
        end else if (Branch_Taken_i) begin
            // Redirect wins over stall; the wrong-path fetch becomes a bubble.
            Instruction_o <= NOP;
            Valid_o       <= 1'b0;
            if (in_range(Branch_Target_i)) begin
                pc_q <= Branch_Target_i;
            end else begin
                Fault_o <= 1'b1;
                state   <= HALT;
            end
        end else if (Stall_i) begin
            if (Flush_i) begin
                Instruction_o <= NOP;
                Valid_o       <= 1'b0;
            end
        end else if (Flush_i) begin
            Instruction_o <= NOP;
            Valid_o       <= 1'b0;
            if (in_range(pc_plus_4)) begin
                pc_q <= pc_plus_4;
            end else begin
                Fault_o <= 1'b1;
                state   <= HALT;
            end
        end else begin
            Instruction_o <= Rom_Instruction_i;
            PC_o          <= pc_q;
            PC_Plus_4_o   <= pc_plus_4;
            Valid_o       <= 1'b1;
            // Running off the end still delivers the last word as valid.
            if (in_range(pc_plus_4)) begin
                pc_q <= pc_plus_4;
            end else begin
                Fault_o <= 1'b1;
                state   <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed per-cycle vectors with
// hand-computed expected outputs, checked by an independent monitor.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic        Branch_Taken_i = 1'b0;
    logic [31:0] Branch_Target_i = 32'h0;
    logic [31:0] Rom_Instruction_i;
    logic [5:0]  Rom_Address_o;
    logic [31:0] Instruction_o;
    logic [31:0] PC_o;
    logic [31:0] PC_Plus_4_o;
    logic        Valid_o;
    logic        Fault_o;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .Stall_i           (Stall_i),
        .Flush_i           (Flush_i),
        .Branch_Taken_i    (Branch_Taken_i),
        .Branch_Target_i   (Branch_Target_i),
        .Rom_Instruction_i (Rom_Instruction_i),
        .Rom_Address_o     (Rom_Address_o),
        .Instruction_o     (Instruction_o),
        .PC_o              (PC_o),
        .PC_Plus_4_o       (PC_Plus_4_o),
        .Valid_o           (Valid_o),
        .Fault_o           (Fault_o)
    );

    // ROM word k holds 32'h1000 + k
    assign Rom_Instruction_i = 32'h0000_1000 + {26'd0, Rom_Address_o};

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [5:0]  ra;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every output record once its edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].edge_no <= cyc) begin
                e = q.pop_front();
                checks++;
                if ({Instruction_o, PC_o, PC_Plus_4_o, Valid_o, Fault_o, Rom_Address_o} !==
                    {e.instr, e.pc, e.pc4, e.valid, e.fault, e.ra}) begin
                    errors++;
                    $display("FAIL %s: got instr=%h pc=%h pc4=%h v=%b f=%b ra=%0d, want instr=%h pc=%h pc4=%h v=%b f=%b ra=%0d",
                             e.name, Instruction_o, PC_o, PC_Plus_4_o, Valid_o, Fault_o, Rom_Address_o,
                             e.instr, e.pc, e.pc4, e.valid, e.fault, e.ra);
                end
            end
        end
    end

    task automatic step(input string nm, input logic rs, input logic st, input logic fl,
                        input logic br, input logic [31:0] tgt,
                        input logic [31:0] ei, input logic [31:0] epc,
                        input logic v, input logic f, input logic [5:0] ra);
        exp_t e;
        reset           = rs;
        Stall_i         = st;
        Flush_i         = fl;
        Branch_Taken_i  = br;
        Branch_Target_i = tgt;
        e.edge_no = cyc + 1;
        e.name    = nm;
        e.instr   = ei;
        e.pc      = epc;
        e.pc4     = epc + 32'd4;
        e.valid   = v;
        e.fault   = f;
        e.ra      = ra;
        q.push_back(e);
        @(negedge clk);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] B   = 32'h0040_0000;

    initial begin
        @(negedge clk);
        //   name            rs st fl br target        instr         pc            v  f  ra
        step("reset0",       1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        step("reset1",       1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        step("run_w0",       0, 0, 0, 0, 32'h0,        32'h1000,     32'h00400000, 1, 0, 1);
        step("run_w1",       0, 0, 0, 0, 32'h0,        32'h1001,     32'h00400004, 1, 0, 2);
        step("run_w2",       0, 0, 0, 0, 32'h0,        32'h1002,     32'h00400008, 1, 0, 3);
        for (int i = 0; i < 3; i++)
            step("stall",    0, 1, 0, 0, 32'h0,        32'h1002,     32'h00400008, 1, 0, 3);
        step("after_stall",  0, 0, 0, 0, 32'h0,        32'h1003,     32'h0040000C, 1, 0, 4);
        step("flush",        0, 0, 1, 0, 32'h0,        NOP,          32'h0040000C, 0, 0, 5);
        step("after_flush",  0, 0, 0, 0, 32'h0,        32'h1005,     32'h00400014, 1, 0, 6);
        step("branch",       0, 0, 0, 1, 32'h00400020, NOP,          32'h00400014, 0, 0, 8);
        step("branch_tgt",   0, 0, 0, 0, 32'h0,        32'h1008,     32'h00400020, 1, 0, 9);
        step("run_w9",       0, 0, 0, 0, 32'h0,        32'h1009,     32'h00400024, 1, 0, 10);
        step("branch_stall", 0, 1, 0, 1, 32'h00400020, NOP,          32'h00400024, 0, 0, 8);
        step("bs_tgt",       0, 0, 0, 0, 32'h0,        32'h1008,     32'h00400020, 1, 0, 9);
        step("stall_flush",  0, 1, 1, 0, 32'h0,        NOP,          32'h00400020, 0, 0, 9);
        step("after_sf",     0, 0, 0, 0, 32'h0,        32'h1009,     32'h00400024, 1, 0, 10);
        step("branch_end",   0, 0, 0, 1, 32'h004000F8, NOP,          32'h00400024, 0, 0, 62);
        step("run_w62",      0, 0, 0, 0, 32'h0,        32'h103E,     32'h004000F8, 1, 0, 63);
        step("last_word",    0, 0, 0, 0, 32'h0,        32'h103F,     32'h004000FC, 1, 1, 63);
        step("halt_br",      0, 0, 0, 1, 32'h00400020, NOP,          32'h004000FC, 0, 1, 63);
        step("halt_flush",   0, 0, 1, 0, 32'h0,        NOP,          32'h004000FC, 0, 1, 63);
        step("reset_halt",   1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        step("rerun_w0",     0, 0, 0, 0, 32'h0,        32'h1000,     32'h00400000, 1, 0, 1);
        step("rerun_w1",     0, 0, 0, 0, 32'h0,        32'h1001,     32'h00400004, 1, 0, 2);
        step("reset_mid",    1, 1, 0, 1, 32'h00400020, NOP,          B,            0, 0, 0);
        step("post_rst_w0",  0, 0, 0, 0, 32'h0,        32'h1000,     32'h00400000, 1, 0, 1);
        step("misaligned",   0, 0, 0, 1, 32'h00400022, NOP,          32'h00400000, 0, 1, 1);
        step("mis_hold",     0, 0, 0, 0, 32'h0,        NOP,          32'h00400000, 0, 1, 1);
        step("mis_ignore",   0, 0, 0, 1, 32'h00400020, NOP,          32'h00400000, 0, 1, 1);
        step("reset_mis",    1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        step("run_w0_b",     0, 0, 0, 0, 32'h0,        32'h1000,     32'h00400000, 1, 0, 1);
        step("below_rom",    0, 0, 0, 1, 32'h00300000, NOP,          32'h00400000, 0, 1, 1);
        step("below_hold",   0, 0, 0, 0, 32'h0,        NOP,          32'h00400000, 0, 1, 1);
        step("reset_below",  1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        step("run_w0_c",     0, 0, 0, 0, 32'h0,        32'h1000,     32'h00400000, 1, 0, 1);
        step("past_rom",     0, 0, 0, 1, 32'h00400100, NOP,          32'h00400000, 0, 1, 1);
        step("reset_final",  1, 0, 0, 0, 32'h0,        NOP,          B,            0, 0, 0);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
